// File: rtl/spi_rom_reader_pkg.sv
// spi_rom_pkg: shared definitions for the SPI ROM read path.
// Holds the read opcode, the word-count width, the chip-select gap length,
// the sequencer state encoding, the SPI clock select codes and the layout
// of the READ command word shifted out to the ROM.
package spi_rom_pkg;

  localparam logic [7:0] CMD_READ       = 8'h03;
  localparam int         LEN_W          = 8;
  localparam int         CS_HIGH_CYCLES = 4;
  localparam int         GAP_W          = $clog2(CS_HIGH_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_GAP,
    ST_DONE
  } state_t;

  // SPI clock select codes passed straight through to the master's freq input.
  typedef enum logic [1:0] {
    FREQ_SLOWEST = 2'b00,
    FREQ_SLOW    = 2'b01,
    FREQ_FAST    = 2'b10,
    FREQ_FASTEST = 2'b11
  } freq_sel_t;

  // Command word as it leaves the master MSB first: opcode, then address.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] addr;
  } cmd_word_t;

  function automatic logic [31:0] make_read_cmd(input logic [23:0] addr);
    cmd_word_t cmd;
    cmd.opcode = CMD_READ;
    cmd.addr   = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_rom_reader_if.sv
// spi_rom_reader_if: bundle of every signal around the ROM reader.
// Requester side: start/addr/len/freq_sel in, busy/done/rd_* out.
// SPI master side: spi_din/spi_freq/spi_en out, spi_dout/spi_done in.
// Modport slave is the reader itself; modport master is whatever drives it
// (the requester plus the SPI master, or a bench standing in for both).
interface spi_rom_reader_if;
  import spi_rom_pkg::*;

  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic [1:0]       freq_sel;
  logic             busy;
  logic             done;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic [LEN_W-1:0] rd_index;
  logic [31:0]      spi_din;
  logic [1:0]       spi_freq;
  logic             spi_en;
  logic [31:0]      spi_dout;
  logic             spi_done;

  modport slave (
    input  start, addr, len, freq_sel, spi_dout, spi_done,
    output busy, done, rd_data, rd_valid, rd_index, spi_din, spi_freq, spi_en
  );

  modport master (
    output start, addr, len, freq_sel, spi_dout, spi_done,
    input  busy, done, rd_data, rd_valid, rd_index, spi_din, spi_freq, spi_en
  );

endinterface

// File: rtl/spi_rom_reader.sv
// spi_rom_reader: sequences one ROM read burst through the 32-bit SPI master.
// A start sends {CMD_READ, addr}, then len dummy words; each word received
// during the dummy transfers is returned on rd_data/rd_valid/rd_index.
// spi_en stays high for the whole burst so chip select stays low, then a
// chip-select-high gap is enforced before the done pulse.
// Ports: clk, rst (async, active high), bus (spi_rom_reader_if.slave).
// All outputs come straight from flops.
module spi_rom_reader
  import spi_rom_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  spi_rom_reader_if.slave bus
);

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt, word_cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [LEN_W-1:0] rd_index_q, rd_index_d;
  logic [31:0]      spi_din_q, spi_din_d;
  logic [1:0]       spi_freq_q, spi_freq_d;
  logic             spi_en_q, spi_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      spi_din_q  <= '0;
      spi_freq_q <= '0;
      spi_en_q   <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      word_cnt   <= word_cnt_d;
      gap_cnt    <= gap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      spi_din_q  <= spi_din_d;
      spi_freq_q <= spi_freq_d;
      spi_en_q   <= spi_en_d;
    end
  end

  // Next state plus the next value of every registered output. busy, spi_en
  // and done are derived from the state being entered so they change on the
  // same edge as the state. DONE accepts a start just like IDLE, which lets
  // bursts run back to back without an idle cycle.
  always_comb begin
    state_d    = state;
    len_d      = len_q;
    word_cnt_d = word_cnt;
    gap_cnt_d  = gap_cnt;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    spi_din_d  = spi_din_q;
    spi_freq_d = spi_freq_q;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          len_d      = bus.len;
          spi_freq_d = bus.freq_sel;
          if (bus.len != '0) begin
            spi_din_d = make_read_cmd(bus.addr);
            state_d   = ST_CMD;
          end else begin
            state_d = ST_DONE;
          end
        end else if (state == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      // The word clocked in while the command goes out is meaningless.
      ST_CMD: begin
        if (bus.spi_done) begin
          spi_din_d  = '0;
          word_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end

      // Comparing against len-1 before incrementing keeps the counter from
      // wrapping even for the largest burst.
      ST_DATA: begin
        if (bus.spi_done) begin
          rd_data_d  = bus.spi_dout;
          rd_index_d = word_cnt;
          rd_valid_d = 1'b1;
          word_cnt_d = word_cnt + LEN_W'(1);
          if (word_cnt == len_q - LEN_W'(1)) begin
            gap_cnt_d = GAP_W'(CS_HIGH_CYCLES);
            state_d   = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_d = ST_DONE;
        end else begin
          gap_cnt_d = gap_cnt - GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d   = (state_d == ST_CMD) || (state_d == ST_DATA) || (state_d == ST_GAP);
    spi_en_d = (state_d == ST_CMD) || (state_d == ST_DATA);
    done_d   = (state_d == ST_DONE);
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_index = rd_index_q;
  assign bus.spi_din  = spi_din_q;
  assign bus.spi_freq = spi_freq_q;
  assign bus.spi_en   = spi_en_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// tb_spi_rom_reader: self-checking bench for spi_rom_reader.
// A behavioural SPI master answers every transfer after a random latency,
// logs each word it samples from spi_din and each word it returns.
// Expected results come from the burst rules: one READ command word followed
// by len zero words, read data equal to the words returned after the command,
// indices 0..len-1, and done CS_HIGH_CYCLES+1 edges after the last transfer.
module tb_spi_rom_reader;
  import spi_rom_pkg::*;

  typedef struct {
    logic [31:0]      data;
    logic [LEN_W-1:0] idx;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_rom_reader_if bus();

  spi_rom_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Master model drives m_*; the tests inject stray pulses through t_*.
  logic        m_done = 1'b0, t_done = 1'b0;
  logic [31:0] m_dout = '0, t_dout = '0;
  assign bus.spi_done = m_done | t_done;
  assign bus.spi_dout = t_done ? t_dout : m_dout;

  logic [31:0] resp_q[$];
  logic [31:0] din_log[$];
  logic [31:0] dout_log[$];
  rd_t         rd_q[$];
  int          done_cyc[$];
  int          cyc = 0;
  int          last_sd_cyc = 0;
  int          en_rises = 0;
  logic        en_prev = 1'b0;
  rd_t         mon_rd;
  int          n_checks = 0;
  int          n_fail = 0;

  // Behavioural master: a transfer starts whenever spi_en is high, and a new
  // one starts in the cycle after spi_done if spi_en is still high.
  initial begin : master_model
    bit aborted;
    forever begin
      @(posedge clk); #1;
      while (bus.spi_en === 1'b1 && !rst) begin
        din_log.push_back(bus.spi_din);
        aborted = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
          if (bus.spi_en !== 1'b1) aborted = 1'b1;
        end
        if (aborted) break;
        m_dout = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom();
        dout_log.push_back(m_dout);
        m_done = 1'b1;
        @(posedge clk); #1;
        m_done = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      mon_rd.data = bus.rd_data;
      mon_rd.idx  = bus.rd_index;
      rd_q.push_back(mon_rd);
    end
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.spi_done === 1'b1 && bus.spi_en === 1'b1) last_sd_cyc = cyc;
    if (bus.spi_en === 1'b1 && en_prev !== 1'b1) en_rises++;
    en_prev = bus.spi_en;
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_logs();
    resp_q.delete();
    din_log.delete();
    dout_log.delete();
    rd_q.delete();
    done_cyc.delete();
    en_rises = 0;
  endtask

  // Request inputs are scrambled right after the accepting edge so any use
  // of unlatched values shows up.
  task automatic start_op(input logic [23:0] a, input logic [LEN_W-1:0] l, input logic [1:0] f);
    bus.start    = 1'b1;
    bus.addr     = a;
    bus.len      = l;
    bus.freq_sel = f;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.addr     = $urandom();
    bus.len      = LEN_W'($urandom());
    bus.freq_sel = 2'($urandom());
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic wait_rd(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (rd_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.addr = '0; bus.len = '0; bus.freq_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.rd_valid, bus.rd_data, bus.rd_index, bus.spi_din, bus.spi_freq, bus.spi_en} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h required 0", {bus.busy, bus.done, bus.rd_valid, bus.rd_data,
               bus.rd_index, bus.spi_din, bus.spi_freq, bus.spi_en});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    bit ok;
    clear_logs();
    resp_q.push_back(32'h0BADC0DE);
    resp_q.push_back(32'hDEADBEEF);
    start_op(24'h000100, LEN_W'(1), 2'b11);
    n_checks++;
    if (bus.spi_din !== 32'h03000100) begin n_fail++; $display("[TB] FAIL single_cmd_word: got %h required 03000100", bus.spi_din); end
    n_checks++;
    if ({bus.busy, bus.spi_en, bus.spi_freq} !== 4'b1111) begin n_fail++; $display("[TB] FAIL single_start_flags: got %b required 1111", {bus.busy, bus.spi_en, bus.spi_freq}); end
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL single_done_timeout: got no done required done"); end
    n_checks++;
    if (din_log.size() != 2 || din_log[1] !== 32'h0) begin n_fail++; $display("[TB] FAIL single_din_seq: got %0d words required 2 words ending 0", din_log.size()); end
    n_checks++;
    if (rd_q.size() != 1 || rd_q[0].data !== 32'hDEADBEEF || rd_q[0].idx !== '0) begin
      n_fail++; $display("[TB] FAIL single_rd: got %0d words required 1 word DEADBEEF index 0", rd_q.size());
    end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] - last_sd_cyc != CS_HIGH_CYCLES + 2) begin
      n_fail++; $display("[TB] FAIL single_done_gap: got %0d cycles required %0d", (done_cyc.size() != 0) ? done_cyc[0] - last_sd_cyc : -1, CS_HIGH_CYCLES + 2);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst4();
    bit ok;
    logic [23:0] a;
    clear_logs();
    a = $urandom();
    resp_q.push_back($urandom());
    for (int i = 1; i <= 4; i++) resp_q.push_back({8{4'(i)}});
    start_op(a, LEN_W'(4), 2'b01);
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL burst4_done_timeout: got no done required done"); end
    n_checks++;
    if (rd_q.size() != 4) begin n_fail++; $display("[TB] FAIL burst4_count: got %0d required 4", rd_q.size()); end
    for (int i = 0; i < rd_q.size() && i < 4; i++) begin
      n_checks++;
      if (rd_q[i].data !== {8{4'(i + 1)}} || rd_q[i].idx !== LEN_W'(i)) begin
        n_fail++; $display("[TB] FAIL burst4_word%0d: got %h/%0d required %h/%0d", i, rd_q[i].data, rd_q[i].idx, {8{4'(i + 1)}}, i);
      end
    end
    n_checks++;
    if (en_rises != 1 || din_log.size() != 5 || din_log[0] !== {8'h03, a}) begin
      n_fail++; $display("[TB] FAIL burst4_spi_en: got %0d rises %0d transfers required 1 rise 5 transfers", en_rises, din_log.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_len_zero();
    clear_logs();
    start_op($urandom(), '0, 2'b10);
    n_checks++;
    if ({bus.done, bus.busy, bus.spi_en} !== 3'b100) begin n_fail++; $display("[TB] FAIL len0_done: got %b required 100", {bus.done, bus.busy, bus.spi_en}); end
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (en_rises != 0 || din_log.size() != 0 || done_cyc.size() != 1) begin
      n_fail++; $display("[TB] FAIL len0_quiet: got %0d rises %0d dones required 0 rises 1 done", en_rises, done_cyc.size());
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [23:0] a1, a3;
    clear_logs();
    a1 = $urandom();
    a3 = $urandom();
    start_op(a1, LEN_W'(3), 2'b00);
    wait_rd(1, 100, ok);
    bus.start = 1'b1; bus.addr = a1 ^ 24'h800000; bus.len = LEN_W'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || !ok) begin n_fail++; $display("[TB] FAIL busy_start_busy: got %b required 1", bus.busy); end
    wait_done(100, ok);
    n_checks++;
    if (!ok || rd_q.size() != 3 || din_log.size() != 4 || din_log[0] !== {8'h03, a1}) begin
      n_fail++; $display("[TB] FAIL busy_start_ignored: got %0d words %0d transfers required 3 words 4 transfers", rd_q.size(), din_log.size());
    end
    clear_logs();
    start_op(a3, LEN_W'(2), 2'b10);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.spi_en !== 1'b1 || bus.spi_din !== {8'h03, a3}) begin
      n_fail++; $display("[TB] FAIL done_cycle_start: got %b%b %h required 11 %h", bus.busy, bus.spi_en, bus.spi_din, {8'h03, a3});
    end
    wait_done(100, ok);
    n_checks++;
    if (!ok || rd_q.size() != 2 || dout_log.size() != 3 || rd_q[1].data !== dout_log[2] || rd_q[1].idx !== LEN_W'(1)) begin
      n_fail++; $display("[TB] FAIL done_cycle_burst: got %0d words required 2", rd_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n_rd;
    clear_logs();
    start_op($urandom(), LEN_W'(4), 2'b01);
    wait_rd(1, 100, ok);
    #2 rst = 1'b1;
    #1;
    n_rd = rd_q.size();
    n_checks++;
    if ({bus.busy, bus.done, bus.rd_valid, bus.rd_data, bus.rd_index, bus.spi_din, bus.spi_freq, bus.spi_en} !== '0) begin
      n_fail++; $display("[TB] FAIL midreset_outputs: got %h required 0", {bus.busy, bus.done, bus.rd_valid, bus.rd_data,
               bus.rd_index, bus.spi_din, bus.spi_freq, bus.spi_en});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    n_checks++;
    if (!ok || rd_q.size() != n_rd || done_cyc.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreset_quiet: got %0d words %0d dones required %0d words 0 dones", rd_q.size(), done_cyc.size(), n_rd);
    end
    clear_logs();
    start_op($urandom(), LEN_W'(3), 2'b11);
    wait_done(100, ok);
    n_checks++;
    if (!ok || rd_q.size() != 3 || dout_log.size() != 4 || rd_q[2].data !== dout_log[3] || rd_q[2].idx !== LEN_W'(2)) begin
      n_fail++; $display("[TB] FAIL midreset_restart: got %0d words required 3", rd_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_done();
    bit ok;
    clear_logs();
    @(negedge clk);
    t_dout = $urandom(); t_done = 1'b1;
    @(negedge clk) t_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rd_q.size() != 0 || done_cyc.size() != 0 || bus.busy !== 1'b0 || bus.spi_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL spurious_idle: got %0d words busy %b required 0 words busy 0", rd_q.size(), bus.busy);
    end
    start_op($urandom(), LEN_W'(2), 2'b00);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && bus.spi_en === 1'b0) begin ok = 1'b1; break; end
    end
    t_dout = $urandom(); t_done = 1'b1;
    @(negedge clk) t_done = 1'b0;
    wait_done(50, ok);
    n_checks++;
    if (!ok || rd_q.size() != 2 || done_cyc.size() != 1 || done_cyc[0] - last_sd_cyc != CS_HIGH_CYCLES + 2) begin
      n_fail++; $display("[TB] FAIL spurious_gap: got %0d words, %0d gap cycles required 2 words, %0d", rd_q.size(),
               (done_cyc.size() != 0) ? done_cyc[0] - last_sd_cyc : -1, CS_HIGH_CYCLES + 2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_random_burst(input string tag, input logic [LEN_W-1:0] l);
    bit ok;
    logic [23:0] a;
    logic [1:0]  f;
    int n;
    a = $urandom();
    f = 2'($urandom());
    n = int'(l);
    clear_logs();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    start_op(a, l, f);
    n_checks++;
    if (bus.spi_freq !== f) begin n_fail++; $display("[TB] FAIL %s_freq: got %b required %b", tag, bus.spi_freq, f); end
    wait_done(n * 8 + 40, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL %s_done_timeout: got no done required done", tag); end
    n_checks++;
    if (din_log.size() != n + 1 || din_log[0] !== {8'h03, a}) begin
      n_fail++; $display("[TB] FAIL %s_cmd: got %0d transfers required %0d", tag, din_log.size(), n + 1);
    end
    for (int i = 1; i < din_log.size(); i++) begin
      n_checks++;
      if (din_log[i] !== 32'h0) begin n_fail++; $display("[TB] FAIL %s_dummy%0d: got %h required 0", tag, i, din_log[i]); end
    end
    n_checks++;
    if (rd_q.size() != n || dout_log.size() != n + 1) begin
      n_fail++; $display("[TB] FAIL %s_count: got %0d words required %0d", tag, rd_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (rd_q[i].data !== dout_log[i + 1] || rd_q[i].idx !== LEN_W'(i)) begin
          n_fail++; $display("[TB] FAIL %s_word%0d: got %h/%0d required %h/%0d", tag, i, rd_q[i].data, rd_q[i].idx, dout_log[i + 1], i);
        end
      end
    end
    n_checks++;
    if (en_rises != 1 || done_cyc.size() != 1 || done_cyc[0] - last_sd_cyc != CS_HIGH_CYCLES + 2) begin
      n_fail++; $display("[TB] FAIL %s_end: got %0d rises %0d dones required 1 rise 1 done after %0d cycles", tag, en_rises, done_cyc.size(), CS_HIGH_CYCLES + 2);
    end
  endtask

  task automatic test_random_bursts();
    for (int it = 0; it < 8; it++) run_random_burst("random", LEN_W'($urandom_range(1, 9)));
  endtask

  task automatic test_max_len();
    run_random_burst("maxlen", '1);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_word();
    test_burst4();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_burst();
    test_spurious_done();
    test_random_bursts();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
